sr_latch_arbiter: RTL

Synchronous controller that shares one external SR latch between `NREQ` requesters. Each requester asks for a set or a clear. The block grants requests round-robin and drives the latch's S/R inputs with fixed-width pulses. It never asserts S and R together, which is the latch's forbidden input. It reads back Q through a synchronizer, checks it, and returns a one-cycle `req_ready` to the granted requester. It sits between control logic and the latch cell and is the only driver of the latch's S/R pins.

---
 rtl/sr_arb_pkg.sv | 20 ++
 rtl/sr_latch_arbiter_rr.sv | 35 +++
 rtl/sr_latch_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sr_arb_pkg.sv
// Shared types and constants for the SR latch arbiter.
// Imported by the top and the round-robin arbiter.
package sr_arb_pkg;

  typedef enum logic [2:0] {
    INIT_DRIVE,
    INIT_SETTLE,
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    ACK
  } state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam int SETTLE_CYCLES = 2;

endpackage

// File: rtl/sr_latch_arbiter_rr.sv
// Round-robin arbiter: first requester at or after the pointer.
// Purely combinational; the pointer lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic          found;
  logic [IW:0]   pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(i);
      if (pos >= (IW+1)'(NREQ)) begin
        pos = pos - (IW+1)'(NREQ);
      end
      if (en_i && !found && req_i[pos[IW-1:0]]) begin
        found               = 1'b1;
        gnt_o[pos[IW-1:0]]  = 1'b1;
        idx_o               = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sr_latch_arbiter.sv
// Shares one external SR latch between NREQ requesters,
// pulsing S/R, verifying Q and acknowledging round-robin.
module sr_latch_arbiter
  import sr_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_op,
  output logic [NREQ-1:0] req_ready,
  output logic            latch_s,
  output logic            latch_r,
  input  logic            latch_q,
  output logic            q_track,
  output logic            busy,
  output logic            err_mismatch
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (PULSE_CYCLES > SETTLE_CYCLES) ?
                        PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] P_C = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] S_C = CW'(SETTLE_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_d;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ready_q;
  logic            s_q;
  logic            r_q;
  logic            q_track_q;
  logic            err_q;
  logic            q_meta_q;
  logic            q_sync_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_op;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign arb_op = req_op[arb_idx];
  assign ptr_d  = (arb_idx == LAST) ? '0 : arb_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT_DRIVE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      ready_q   <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      q_track_q <= 1'b0;
      err_q     <= 1'b0;
      q_meta_q  <= 1'b0;
      q_sync_q  <= 1'b0;
    end else begin
      q_meta_q <= latch_q;
      q_sync_q <= q_meta_q;
      ready_q  <= '0;
      unique case (state_q)
        INIT_DRIVE: begin
          if (cnt_q == P_C) begin
            r_q     <= 1'b0;
            cnt_q   <= CW'(1);
            state_q <= INIT_SETTLE;
          end else begin
            r_q   <= 1'b1;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        INIT_SETTLE: begin
          if (cnt_q == S_C) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        IDLE: begin
          if (|req_valid) begin
            gnt_q <= arb_gnt;
            ptr_q <= ptr_d;
            // Latch already holds the requested value: skip the pulse.
            if (arb_op == q_track_q) begin
              ready_q <= arb_gnt;
              state_q <= ACK;
            end else begin
              q_track_q <= arb_op;
              s_q       <= (arb_op == OP_SET);
              r_q       <= (arb_op == OP_CLR);
              cnt_q     <= CW'(1);
              state_q   <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (cnt_q == P_C) begin
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            cnt_q   <= CW'(1);
            state_q <= SETTLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == S_C) begin
            cnt_q   <= '0;
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        CHECK: begin
          if (q_sync_q != q_track_q) begin
            err_q <= 1'b1;
          end
          ready_q <= gnt_q;
          state_q <= ACK;
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= INIT_DRIVE;
          cnt_q   <= '0;
          s_q     <= 1'b0;
          r_q     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = ready_q;
  assign latch_s      = s_q;
  assign latch_r      = r_q;
  assign q_track      = q_track_q;
  assign err_mismatch = err_q;
  assign busy         = (state_q != IDLE);

endmodule
